ysyx_22050039_ctrl_fsm: RTL and testbench
=========================================

# ysyx_22050039_ctrl_fsm

Multi-cycle sequencing controller for the RV64 core. Owns the instruction lifecycle FETCH → DECODE → EXEC → MEM → WB around the fetch unit, decoder, execute unit and load/store unit. It latches the fetched instruction and the decoder's control flags, and issues single-cycle register-file and PC write strobes. It also halts the core on `ebreak` or an invalid instruction.

## Interface
Parameters:
- `XLEN`, 64, width of the performance counters
- `INST_LEN`, 32, instruction width

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset; asynchronous, active-high
- `ifu_req`  out  1  fetch request, held in FETCH until `ifu_valid`
- `ifu_valid`  in  1  fetch data valid; ignored outside FETCH
- `inst_in`  in  INST_LEN  fetched instruction
- `inst`  out  INST_LEN  latched instruction driven to the decoder
- `dec_load`, `dec_store`  in  1 each  decoder: memory read / write
- `dec_jump`  in  1  decoder: PC takes the computed target
- `dec_wreg`  in  1  decoder: instruction writes rd
- `dec_ebreak`, `dec_invalid`  in  1 each  decoder: special/invalid
- `lsu_req`  out  1  memory request, held in MEM until `lsu_done`
- `lsu_wr`  out  1  1 = store, 0 = load; valid while `lsu_req`
- `lsu_done`  in  1  memory complete; ignored outside MEM
- `reg_wen`  out  1  register-file write strobe (WB only)
- `pc_wen`  out  1  PC update strobe (WB only)
- `pc_sel_jump`  out  1  latched `dec_jump`; PC mux select
- `halt`  out  1  sticky halt
- `trap_invalid`  out  1  sticky; halt was caused by an invalid instruction
- `state`  out  3  current state encoding, for debug
- `cycle_cnt`, `instret_cnt`  out  XLEN each  performance counters

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- **IDLE:** entered on reset; exits to FETCH after one cycle.
- **FETCH:** `ifu_req`=1. When `ifu_valid`=1, latch `inst` ← `inst_in` and go to DECODE. Otherwise stay.
- **DECODE:** sample and register `dec_*`.
  - If `dec_invalid`, or `dec_load` and `dec_store` are both set: go to HALT with `trap_invalid` ← 1.
  - Else if `dec_ebreak`: go to HALT with `trap_invalid` ← 0.
  - Otherwise go to EXEC.
  - `dec_invalid` has priority over `dec_ebreak`.
- **EXEC:** one cycle. Go to MEM if the latched load or store flag is set; otherwise go to WB.
- **MEM:** `lsu_req`=1, `lsu_wr` = latched store flag. On `lsu_done`=1 go to WB.
- **WB:**
  - `pc_wen`=1 unconditionally.
  - `reg_wen` = latched `dec_wreg`.
  - Next state is FETCH.
- **HALT:** terminal. `halt`=1; all strobes and requests 0. Left only by reset.
- `pc_sel_jump` holds the latched `dec_jump` from DECODE until the next DECODE.
- Unused decoder inputs in any state other than DECODE are don't-care.

## Timing
- All outputs are registered-state decodes; no combinational path exists from inputs to outputs.
- Reset values: `state`=IDLE; `inst`=0; `ifu_req`, `lsu_req`, `lsu_wr`, `reg_wen`, `pc_wen`, `pc_sel_jump`, `halt`, `trap_invalid` = 0; counters = 0.
- Reset mid-instruction (any state): immediate return to IDLE. An in-flight fetch or memory request is dropped, and no WB strobe is issued.
- Minimum latency with a one-cycle fetch (`ifu_valid` in the first FETCH cycle):
  - ALU/jump instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store with a one-cycle `lsu_done`: 5 cycles.
  - Each stall cycle in FETCH or MEM adds 1.
- `reg_wen` and `pc_wen` are high for exactly one cycle per retired instruction.
- A `ifu_valid` or `lsu_done` pulse in a non-matching state has no effect and is not remembered.

## Configuration
- `YSYX_22050039_PERF_CNT_EN` defined:
  - `cycle_cnt` increments by 1 every cycle the state is not IDLE or HALT.
  - `instret_cnt` increments by 1 on each WB cycle.
  - Both wrap modulo 2^XLEN and freeze in HALT.
- Macro undefined: no counter registers are built; both outputs are constant 0.

## Test plan
- Reset, then `addi` with `ifu_valid` in the first FETCH cycle → `state` 0,1,2,3,5,1; `reg_wen`=1 and `pc_wen`=1 only in cycle 5; `pc_sel_jump`=0.
- `sd` with `dec_store`=1, `lsu_done` after 3 MEM cycles → `lsu_req`=1 and `lsu_wr`=1 for 3 cycles; then WB with `reg_wen`=0 and `pc_wen`=1.
- `jal` with `dec_jump`=1, `dec_wreg`=1, `ifu_valid` delayed 2 cycles → FETCH lasts 3 cycles; `pc_sel_jump`=1 in WB; 6 cycles total.
- `dec_ebreak`=1 and `dec_invalid`=1 together → HALT with `trap_invalid`=1; subsequent `ifu_valid` pulses are ignored; `ifu_req` stays 0.
- Assert `rst` in MEM while `lsu_req`=1 → same cycle `lsu_req`=0 and `state`=0; after release, fetch restarts with no WB strobe.
- With the macro defined, run 3 `addi` instructions followed by `ebreak` → `instret_cnt`=3, `cycle_cnt`=14 (3×4 + 2 for the ebreak's FETCH and DECODE), frozen in HALT.

Source files
------------

// File: rtl/ysyx_22050039_ctrl_fsm_if.sv
// Handshake bundle between the sequencing controller and the fetch unit,
// decoder, load/store unit and writeback/PC logic.
// master: the controller.  slave: the surrounding datapath.
interface ysyx_22050039_ctrl_fsm_if #(
  parameter int INST_LEN = 32
);
  logic                ifu_req;
  logic                ifu_valid;
  logic [INST_LEN-1:0] inst_in;
  logic [INST_LEN-1:0] inst;
  logic                dec_load;
  logic                dec_store;
  logic                dec_jump;
  logic                dec_wreg;
  logic                dec_ebreak;
  logic                dec_invalid;
  logic                lsu_req;
  logic                lsu_wr;
  logic                lsu_done;
  logic                reg_wen;
  logic                pc_wen;
  logic                pc_sel_jump;

  modport master (
    output ifu_req, inst, lsu_req, lsu_wr, reg_wen, pc_wen, pc_sel_jump,
    input  ifu_valid, inst_in, dec_load, dec_store, dec_jump, dec_wreg,
           dec_ebreak, dec_invalid, lsu_done
  );

  modport slave (
    input  ifu_req, inst, lsu_req, lsu_wr, reg_wen, pc_wen, pc_sel_jump,
    output ifu_valid, inst_in, dec_load, dec_store, dec_jump, dec_wreg,
           dec_ebreak, dec_invalid, lsu_done
  );
endinterface

// File: rtl/ysyx_22050039_ctrl_fsm.sv
// Multi-cycle sequencing controller: IDLE -> FETCH -> DECODE -> EXEC
// (-> MEM) -> WB -> FETCH, with a terminal HALT on ebreak or an invalid
// instruction. All outputs decode the registered state or registered
// latches, so there is no combinational input-to-output path.
// Optional build macro: YSYX_22050039_PERF_CNT_EN enables the cycle and
// retired-instruction counters; without it both counters read 0.
module ysyx_22050039_ctrl_fsm #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_22050039_ctrl_fsm_if.master bus,
  output logic                 halt,
  output logic                 trap_invalid,
  output logic [2:0]           state,
  output logic [XLEN-1:0]      cycle_cnt,
  output logic [XLEN-1:0]      instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [INST_LEN-1:0] inst_q;
  logic                load_q;
  logic                store_q;
  logic                jump_q;
  logic                wreg_q;
  logic                trap_q;

  logic                ifu_req_c;
  logic                lsu_req_c;
  logic                lsu_wr_c;
  logic                reg_wen_c;
  logic                pc_wen_c;
  logic                halt_c;

  // A load and a store flagged together is a decoder contradiction; it is
  // treated exactly like an invalid opcode.
  logic                dec_bad;
  assign dec_bad = bus.dec_invalid || (bus.dec_load && bus.dec_store);

  // State register; reset drops any in-flight request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and per-state output strobes.
  always_comb begin
    state_d   = state_q;
    ifu_req_c = 1'b0;
    lsu_req_c = 1'b0;
    lsu_wr_c  = 1'b0;
    reg_wen_c = 1'b0;
    pc_wen_c  = 1'b0;
    halt_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        ifu_req_c = 1'b1;
        if (bus.ifu_valid) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_bad || bus.dec_ebreak) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = (load_q || store_q) ? S_MEM : S_WB;
      end
      S_MEM: begin
        lsu_req_c = 1'b1;
        lsu_wr_c  = store_q;
        if (bus.lsu_done) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_wen_c  = 1'b1;
        reg_wen_c = wreg_q;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halt_c  = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Instruction and decoder-flag latches; trap cause is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= '0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      jump_q  <= 1'b0;
      wreg_q  <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      if (state_q == S_FETCH && bus.ifu_valid) begin
        inst_q <= bus.inst_in;
      end
      if (state_q == S_DECODE) begin
        load_q  <= bus.dec_load;
        store_q <= bus.dec_store;
        jump_q  <= bus.dec_jump;
        wreg_q  <= bus.dec_wreg;
        if (dec_bad) begin
          trap_q <= 1'b1;
        end
      end
    end
  end

`ifdef YSYX_22050039_PERF_CNT_EN
  logic [XLEN-1:0] cycle_q;
  logic [XLEN-1:0] instret_q;

  // Performance counters: busy cycles and retired instructions, frozen in
  // IDLE and HALT, wrapping naturally at 2^XLEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_HALT) begin
        cycle_q <= cycle_q + 1'b1;
      end
      if (state_q == S_WB) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

  assign bus.ifu_req     = ifu_req_c;
  assign bus.lsu_req     = lsu_req_c;
  assign bus.lsu_wr      = lsu_wr_c;
  assign bus.reg_wen     = reg_wen_c;
  assign bus.pc_wen      = pc_wen_c;
  assign bus.pc_sel_jump = jump_q;
  assign bus.inst        = inst_q;
  assign halt            = halt_c;
  assign trap_invalid    = trap_q;
  assign state           = state_q;

endmodule

// File: tb/tb_ysyx_22050039_ctrl_fsm.sv
// Directed, table-driven bench for the sequencing controller. Each table
// row is one clock cycle: expected outputs for the current state and the
// inputs presented for the following rising edge.
module tb_ysyx_22050039_ctrl_fsm;

  localparam int XLEN     = 64;
  localparam int INST_LEN = 32;

  localparam logic [31:0] I_ADDI = 32'h00100093;
  localparam logic [31:0] I_SD   = 32'h00113023;
  localparam logic [31:0] I_JAL  = 32'h008000ef;
  localparam logic [31:0] I_LD   = 32'h00013083;
  localparam logic [31:0] I_EBRK = 32'h00100073;
  localparam logic [31:0] I_JUNK = 32'hdeadbeef;

  // dec = {load, store, jump, wreg, ebreak, invalid}
  localparam logic [5:0] D_NONE  = 6'b000000;
  localparam logic [5:0] D_WREG  = 6'b000100;
  localparam logic [5:0] D_STORE = 6'b010000;
  localparam logic [5:0] D_JW    = 6'b001100;
  localparam logic [5:0] D_LW    = 6'b100100;
  localparam logic [5:0] D_EB    = 6'b000010;
  localparam logic [5:0] D_EBINV = 6'b000011;
  localparam logic [5:0] D_INV   = 6'b000001;
  localparam logic [5:0] D_LDST  = 6'b110000;

  // o = {ifu_req, lsu_req, lsu_wr, reg_wen, pc_wen, pc_sel_jump, halt}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_IF   = 7'b1000000;
  localparam logic [6:0] O_IFJ  = 7'b1000010;
  localparam logic [6:0] O_MEMW = 7'b0110000;
  localparam logic [6:0] O_MEMR = 7'b0100000;
  localparam logic [6:0] O_WBR  = 7'b0001100;
  localparam logic [6:0] O_WB   = 7'b0000100;
  localparam logic [6:0] O_WBRJ = 7'b0001110;
  localparam logic [6:0] O_J    = 7'b0000010;
  localparam logic [6:0] O_H    = 7'b0000001;

  typedef struct {
    logic        iv;
    logic [31:0] ii;
    logic [5:0]  dec;
    logic        ld;
    logic [2:0]  st;
    logic [6:0]  o;
    logic        tr;
    logic [31:0] ei;
  } vec_t;

  logic            clk;
  logic            rst;
  logic            halt;
  logic            trap_invalid;
  logic [2:0]      state;
  logic [XLEN-1:0] cycle_cnt;
  logic [XLEN-1:0] instret_cnt;

  int n_total;
  int n_pass;

  ysyx_22050039_ctrl_fsm_if #(.INST_LEN(INST_LEN)) bus ();

  ysyx_22050039_ctrl_fsm #(.XLEN(XLEN), .INST_LEN(INST_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .halt         (halt),
    .trap_invalid (trap_invalid),
    .state        (state),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic iv, input logic [31:0] ii,
                              input logic [5:0] dec, input logic ld,
                              input logic [2:0] st, input logic [6:0] o,
                              input logic tr, input logic [31:0] ei);
    vec_t v;
    v.iv = iv; v.ii = ii; v.dec = dec; v.ld = ld;
    v.st = st; v.o = o; v.tr = tr; v.ei = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input int row,
                     input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ii,
                       input logic [5:0] dec, input logic ld);
    bus.ifu_valid   = iv;
    bus.inst_in     = ii;
    bus.dec_load    = dec[5];
    bus.dec_store   = dec[4];
    bus.dec_jump    = dec[3];
    bus.dec_wreg    = dec[2];
    bus.dec_ebreak  = dec[1];
    bus.dec_invalid = dec[0];
    bus.lsu_done    = ld;
  endtask

  // Called at a falling edge: compare current outputs, present next inputs.
  task automatic run_row(input string tag, input int idx, input vec_t v);
    chk({tag, ".state"},       idx, 64'(state),           64'(v.st));
    chk({tag, ".ifu_req"},     idx, 64'(bus.ifu_req),     64'(v.o[6]));
    chk({tag, ".lsu_req"},     idx, 64'(bus.lsu_req),     64'(v.o[5]));
    chk({tag, ".lsu_wr"},      idx, 64'(bus.lsu_wr),      64'(v.o[4]));
    chk({tag, ".reg_wen"},     idx, 64'(bus.reg_wen),     64'(v.o[3]));
    chk({tag, ".pc_wen"},      idx, 64'(bus.pc_wen),      64'(v.o[2]));
    chk({tag, ".pc_sel_jump"}, idx, 64'(bus.pc_sel_jump), 64'(v.o[1]));
    chk({tag, ".halt"},        idx, 64'(halt),            64'(v.o[0]));
    chk({tag, ".trap_invalid"},idx, 64'(trap_invalid),    64'(v.tr));
    chk({tag, ".inst"},        idx, 64'(bus.inst),        64'(v.ei));
    drive(v.iv, v.ii, v.dec, v.ld);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, D_NONE, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t main_v[29];
  vec_t trap_v[4];
  vec_t cnt_v[17];
  logic [63:0] exp_cyc;
  logic [63:0] exp_ret;

  initial begin
    n_total = 0;
    n_pass  = 0;
`ifdef YSYX_22050039_PERF_CNT_EN
    exp_cyc = 64'd14;
    exp_ret = 64'd3;
`else
    exp_cyc = 64'd0;
    exp_ret = 64'd0;
`endif

    // addi, sd (3 MEM cycles), jal (2 FETCH stalls), ld (stray lsu_done
    // in EXEC), then ebreak+invalid into HALT with ignored pulses.
    main_v[0]  = mk(0, 32'h0,  D_NONE,  0, 3'd0, O_NONE, 0, 32'h0);
    main_v[1]  = mk(1, I_ADDI, D_NONE,  0, 3'd1, O_IF,   0, 32'h0);
    main_v[2]  = mk(0, I_JUNK, D_WREG,  0, 3'd2, O_NONE, 0, I_ADDI);
    main_v[3]  = mk(1, I_JUNK, D_INV,   1, 3'd3, O_NONE, 0, I_ADDI);
    main_v[4]  = mk(0, 32'h0,  D_NONE,  0, 3'd5, O_WBR,  0, I_ADDI);
    main_v[5]  = mk(1, I_SD,   D_NONE,  0, 3'd1, O_IF,   0, I_ADDI);
    main_v[6]  = mk(0, 32'h0,  D_STORE, 0, 3'd2, O_NONE, 0, I_SD);
    main_v[7]  = mk(0, 32'h0,  D_INV,   0, 3'd3, O_NONE, 0, I_SD);
    main_v[8]  = mk(0, 32'h0,  D_NONE,  0, 3'd4, O_MEMW, 0, I_SD);
    main_v[9]  = mk(0, 32'h0,  D_NONE,  0, 3'd4, O_MEMW, 0, I_SD);
    main_v[10] = mk(0, 32'h0,  D_NONE,  1, 3'd4, O_MEMW, 0, I_SD);
    main_v[11] = mk(0, 32'h0,  D_NONE,  0, 3'd5, O_WB,   0, I_SD);
    main_v[12] = mk(0, I_JAL,  D_NONE,  0, 3'd1, O_IF,   0, I_SD);
    main_v[13] = mk(0, I_JAL,  D_NONE,  1, 3'd1, O_IF,   0, I_SD);
    main_v[14] = mk(1, I_JAL,  D_NONE,  0, 3'd1, O_IF,   0, I_SD);
    main_v[15] = mk(0, 32'h0,  D_JW,    0, 3'd2, O_NONE, 0, I_JAL);
    main_v[16] = mk(0, 32'h0,  D_NONE,  0, 3'd3, O_J,    0, I_JAL);
    main_v[17] = mk(0, 32'h0,  D_NONE,  0, 3'd5, O_WBRJ, 0, I_JAL);
    main_v[18] = mk(1, I_LD,   D_NONE,  0, 3'd1, O_IFJ,  0, I_JAL);
    main_v[19] = mk(0, 32'h0,  D_LW,    0, 3'd2, O_J,    0, I_LD);
    main_v[20] = mk(0, 32'h0,  D_NONE,  1, 3'd3, O_NONE, 0, I_LD);
    main_v[21] = mk(0, 32'h0,  D_NONE,  0, 3'd4, O_MEMR, 0, I_LD);
    main_v[22] = mk(0, 32'h0,  D_NONE,  1, 3'd4, O_MEMR, 0, I_LD);
    main_v[23] = mk(0, 32'h0,  D_NONE,  0, 3'd5, O_WBR,  0, I_LD);
    main_v[24] = mk(1, I_EBRK, D_NONE,  0, 3'd1, O_IF,   0, I_LD);
    main_v[25] = mk(0, 32'h0,  D_EBINV, 0, 3'd2, O_NONE, 0, I_EBRK);
    main_v[26] = mk(1, I_JUNK, D_NONE,  1, 3'd6, O_H,    1, I_EBRK);
    main_v[27] = mk(1, I_JUNK, D_INV,   1, 3'd6, O_H,    1, I_EBRK);
    main_v[28] = mk(0, 32'h0,  D_NONE,  0, 3'd6, O_H,    1, I_EBRK);

    // Load and store flagged together traps as invalid.
    trap_v[0] = mk(0, 32'h0, D_NONE, 0, 3'd0, O_NONE, 0, 32'h0);
    trap_v[1] = mk(1, I_LD,  D_NONE, 0, 3'd1, O_IF,   0, 32'h0);
    trap_v[2] = mk(0, 32'h0, D_LDST, 0, 3'd2, O_NONE, 0, I_LD);
    trap_v[3] = mk(1, I_SD,  D_NONE, 1, 3'd6, O_H,    1, I_LD);

    // Three addi then a plain ebreak (halt without trap).
    cnt_v[0] = mk(0, 32'h0, D_NONE, 0, 3'd0, O_NONE, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cnt_v[1 + 4*k] = mk(1, I_ADDI, D_NONE, 0, 3'd1, O_IF, 0,
                          (k == 0) ? 32'h0 : I_ADDI);
      cnt_v[2 + 4*k] = mk(0, 32'h0, D_WREG, 0, 3'd2, O_NONE, 0, I_ADDI);
      cnt_v[3 + 4*k] = mk(0, 32'h0, D_NONE, 0, 3'd3, O_NONE, 0, I_ADDI);
      cnt_v[4 + 4*k] = mk(0, 32'h0, D_NONE, 0, 3'd5, O_WBR,  0, I_ADDI);
    end
    cnt_v[13] = mk(1, I_EBRK, D_NONE, 0, 3'd1, O_IF,   0, I_ADDI);
    cnt_v[14] = mk(0, 32'h0,  D_EB,   0, 3'd2, O_NONE, 0, I_EBRK);
    cnt_v[15] = mk(1, I_JUNK, D_NONE, 0, 3'd6, O_H,    0, I_EBRK);
    cnt_v[16] = mk(0, 32'h0,  D_NONE, 0, 3'd6, O_H,    0, I_EBRK);

    // Asynchronous reset values.
    drive(1'b0, 32'h0, D_NONE, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst.state",        0, 64'(state),           64'd0);
    chk("rst.ifu_req",      0, 64'(bus.ifu_req),     64'd0);
    chk("rst.lsu_req",      0, 64'(bus.lsu_req),     64'd0);
    chk("rst.lsu_wr",       0, 64'(bus.lsu_wr),      64'd0);
    chk("rst.reg_wen",      0, 64'(bus.reg_wen),     64'd0);
    chk("rst.pc_wen",       0, 64'(bus.pc_wen),      64'd0);
    chk("rst.pc_sel_jump",  0, 64'(bus.pc_sel_jump), 64'd0);
    chk("rst.halt",         0, 64'(halt),            64'd0);
    chk("rst.trap_invalid", 0, 64'(trap_invalid),    64'd0);
    chk("rst.inst",         0, 64'(bus.inst),        64'd0);
    chk("rst.cycle_cnt",    0, cycle_cnt,            64'd0);
    chk("rst.instret_cnt",  0, instret_cnt,          64'd0);
    do_reset();

    for (int i = 0; i < 29; i++) run_row("main", i, main_v[i]);

    do_reset();
    for (int i = 0; i < 4; i++) run_row("ldst", i, trap_v[i]);
    chk("ldst.halt_hold",  0, 64'(halt),        64'd1);
    chk("ldst.ifu_req",    0, 64'(bus.ifu_req), 64'd0);

    // Reset asserted while a store is waiting in MEM.
    do_reset();
    run_row("rmem", 0, mk(0, 32'h0, D_NONE,  0, 3'd0, O_NONE, 0, 32'h0));
    run_row("rmem", 1, mk(1, I_SD,  D_NONE,  0, 3'd1, O_IF,   0, 32'h0));
    run_row("rmem", 2, mk(0, 32'h0, D_STORE, 0, 3'd2, O_NONE, 0, I_SD));
    run_row("rmem", 3, mk(0, 32'h0, D_NONE,  0, 3'd3, O_NONE, 0, I_SD));
    chk("rmem.lsu_req_pre", 4, 64'(bus.lsu_req), 64'd1);
    chk("rmem.state_pre",   4, 64'(state),       64'd4);
    #1 rst = 1'b1;
    #1;
    chk("rmem.lsu_req_rst", 4, 64'(bus.lsu_req), 64'd0);
    chk("rmem.lsu_wr_rst",  4, 64'(bus.lsu_wr),  64'd0);
    chk("rmem.state_rst",   4, 64'(state),       64'd0);
    bus.lsu_done = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.lsu_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rmem.reg_wen_after", i, 64'(bus.reg_wen), 64'd0);
      chk("rmem.pc_wen_after",  i, 64'(bus.pc_wen),  64'd0);
      @(negedge clk);
    end
    chk("rmem.state_refetch",   5, 64'(state),       64'd1);
    chk("rmem.ifu_req_refetch", 5, 64'(bus.ifu_req), 64'd1);
    chk("rmem.inst_cleared",    5, 64'(bus.inst),    64'd0);

    // Counter sequence.
    do_reset();
    chk("cnt.cycle_start", 0, cycle_cnt, 64'd0);
    for (int i = 0; i < 17; i++) run_row("cnt", i, cnt_v[i]);
    chk("cnt.cycle_cnt",   0, cycle_cnt,   exp_cyc);
    chk("cnt.instret_cnt", 0, instret_cnt, exp_ret);
    repeat (5) @(negedge clk);
    chk("cnt.cycle_frozen",   1, cycle_cnt,   exp_cyc);
    chk("cnt.instret_frozen", 1, instret_cnt, exp_ret);
    chk("cnt.halt_trap",      1, 64'(trap_invalid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
